// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//   - state encoding (IDLE/RUN/DONE) as localparams plus a typed enum
//   - cnt_width(): width of the bit counter for a given operand width
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // One spare bit over $clog2 so the counter is at least 1 bit wide
    // even for width = 1.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// fa
//   One-bit full adder cell, purely combinational.
//   Ports:
//     A, B   in   operand bits
//     C      in   carry-in bit
//     SUM    out  A ^ B ^ C
//     COUT   out  majority(A, B, C)
module fa (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic SUM,
    output logic COUT
);

    assign SUM  = A ^ B ^ C;
    assign COUT = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial, LSB-first adder: {cout, sum} = a + b + cin, one bit per
//   cycle through a single full-adder cell, carry held in a flop.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   asynchronous active-high reset
//     start  in   request, sampled only in IDLE or DONE
//     a, b   in   operands (WIDTH), captured on the accepting edge
//     cin    in   carry-in, captured on the accepting edge
//     busy   out  high while bits are being processed
//     done   out  one-cycle pulse, sum/cout just updated
//     sum    out  result register (WIDTH)
//     cout   out  final carry register
//
//   Handshake: start is a level request with no ready signal; it is
//   accepted on any rising edge where the block is in IDLE or DONE (busy=0)
//   and ignored while busy=1. Each accepted request yields exactly one
//   done pulse WIDTH cycles after the accepting edge, unless rst aborts it.
//   sum/cout change only on the edge that raises done.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    count;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;

    fa u_fa (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .C    (carry),
        .SUM  (fa_sum),
        .COUT (fa_cout)
    );

    // sum_sr with this cycle's SUM bit shifted in at the MSB; on the last
    // RUN edge this is the complete result.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_next = fa_sum;
        end else begin : g_wn
            assign sum_next = {fa_sum, sum_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next;
                    carry  <= fa_cout;
                    count  <= count + ONE;
                    if (count == LAST) begin
                        sum   <= sum_next;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Self-checking bench for serial_adder at WIDTH=8, 4 and 1. Expected
//   results come from plain integer addition a + b + cin.
module tb_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
    logic [0:0] a1 = '0, b1 = '0, sum1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );
    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks (WIDTH=8) ----------------
    // Presents an operation for one edge (edge 0) and returns in the
    // cycle after it; the reference result goes on the expected queue.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    // Waits for done, starting lat0 cycles after the accepting edge, then
    // checks latency, busy duration, result hold during RUN and the result.
    task automatic result8(input string tag, input int lat0);
        int         lat;
        int         busy_cnt;
        int         sum_moves;
        logic [8:0] held;
        logic [8:0] e;
        lat = lat0; busy_cnt = 0; sum_moves = 0;
        held = {cout8, sum8};
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) busy_cnt++;
            if ({cout8, sum8} !== held) sum_moves++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_busy_cycles"}, busy_cnt, 8 - lat0);
        check({tag, "_held_in_run"}, sum_moves, 0);
        check({tag, "_busy_at_done"}, busy8, 0);
        e = exp_q.pop_front();
        check({tag, "_sum"}, sum8, e[7:0]);
        check({tag, "_cout"}, cout8, e[8]);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
        launch8(a, b, c);
        result8(tag, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done8, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int done_seen;

        // Reset asserted before any clock edge: outputs must be cleared.
        #2;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_out4", {busy4, done4, cout4, sum4}, 0);
        check("rst_out1", {busy1, done1, cout1, sum1}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run8("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
        run8("add_ff_01", 8'hFF, 8'h01, 1'b0);
        run8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1);

        // start during RUN is ignored; start held through DONE is accepted.
        launch8(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        result8("ignore_in_run", 4);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        exp_q.push_back(9'h030);
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_busy", busy8, 1);
        result8("back_to_back", 0);
        @(negedge clk);
        check("b2b_done_pulse", done8, 0);

        // Asynchronous abort at RUN cycle 4.
        launch8(8'hAA, 8'h55, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_sum", sum8, 0);
        check("abort_cout", cout8, 0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_idle", busy8, 0);
        run8("after_abort", 8'h01, 8'h02, 1'b1);

        // Random operands.
        for (int i = 0; i < 20; i++) begin
            run8("rand", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // WIDTH=4 exhaustive sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    lat = 0;
                    while (done4 !== 1'b1 && lat < 20) begin
                        @(negedge clk);
                        lat++;
                    end
                    check("w4_latency", lat, 4);
                    check("w4_result", {cout4, sum4}, ia + ib + ic);
                end
            end
        end

        // WIDTH=1 exhaustive sweep.
        for (int ia = 0; ia < 2; ia++) begin
            for (int ib = 0; ib < 2; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    a1 = 1'(ia); b1 = 1'(ib); cin1 = 1'(ic); start1 = 1'b1;
                    @(negedge clk);
                    start1 = 1'b0;
                    lat = 0;
                    while (done1 !== 1'b1 && lat < 20) begin
                        @(negedge clk);
                        lat++;
                    end
                    check("w1_latency", lat, 1);
                    check("w1_busy_at_done", busy1, 0);
                    check("w1_result", {cout1, sum1}, ia + ib + ic);
                end
            end
        end

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
